// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream scan controller and the
// pipelines it drives.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ceiling log2, never narrower than one bit so it can size any port.
    function automatic int log2(input int value);
        int result;
        result = 1;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Cycles from a pixel entering a patch pipeline until its patch is complete.
    function automatic int pipe_latency(input int patch_height, input int patch_width,
                                        input int center_v, input int center_h,
                                        input int frame_width);
        return (patch_height - 32'sd1 - center_v) * frame_width
             + (patch_width - 32'sd1 - center_h) + 32'sd2;
    endfunction

endpackage

// File: rtl/stream_scan_ctrl_scan_counter.sv
// Raster position counter: hcnt runs fastest and wraps into vcnt; both
// advance only when adv is high.
module scan_counter
    import stream_pkg::*;
#(
    parameter int FRAME_HEIGHT = 525,
    parameter int FRAME_WIDTH  = 800
) (
    input  logic                           clock,
    input  logic                           n_rst,
    input  logic                           clear,
    input  logic                           adv,
    output logic [log2(FRAME_HEIGHT)-1:0]  vcnt,
    output logic [log2(FRAME_WIDTH)-1:0]   hcnt,
    output logic                           frame_end
);

    localparam int VW = log2(FRAME_HEIGHT);
    localparam int HW = log2(FRAME_WIDTH);

    logic last_col_s;
    logic last_row_s;

    assign last_col_s = (hcnt == HW'(FRAME_WIDTH - 1));
    assign last_row_s = (vcnt == VW'(FRAME_HEIGHT - 1));
    assign frame_end  = adv && last_col_s && last_row_s;

    // Position register with wrap at line and frame end.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            vcnt <= '0;
            hcnt <= '0;
        end else if (clear) begin
            vcnt <= '0;
            hcnt <= '0;
        end else if (adv) begin
            if (last_col_s) begin
                hcnt <= '0;
                vcnt <= last_row_s ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/stream_scan_ctrl.sv
// Frame sequencer for a patch-extraction pipeline: merges a valid/ready
// pixel source into a full raster scan and flushes the pipeline at the end.
module stream_scan_ctrl
    import stream_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 480,
    parameter int IMAGE_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 525,
    parameter int FRAME_WIDTH  = 800,
    parameter int DRAIN_CYCLES = 2 * FRAME_WIDTH + 4,
    parameter int FRAMES_BITW  = 16
) (
    input  logic                           clock,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic [FRAMES_BITW-1:0]         num_frames,
    output logic                           busy,
    output logic                           done,
    input  logic                           src_valid,
    input  logic [BIT_WIDTH-1:0]           src_pixel,
    output logic                           src_ready,
    input  logic                           dst_stall,
    output logic                           out_enable,
    output logic [BIT_WIDTH-1:0]           out_pixel,
    output logic [log2(FRAME_HEIGHT)-1:0]  out_vcnt,
    output logic [log2(FRAME_WIDTH)-1:0]   out_hcnt
);

    localparam int VW = log2(FRAME_HEIGHT);
    localparam int HW = log2(FRAME_WIDTH);
    localparam int DW = log2(DRAIN_CYCLES + 1);
    localparam int FW = FRAMES_BITW + 1;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [FRAMES_BITW-1:0] nf_r;
    logic [FRAMES_BITW-1:0] frame_cnt_r;
    logic [DW-1:0]          drain_cnt_r;
    logic [VW-1:0]          vcnt_s;
    logic [HW-1:0]          hcnt_s;
    logic                   frame_end_s;
    logic                   active_s;
    logic                   run_adv_s;
    logic                   adv_s;
    logic                   clear_s;
    logic                   last_frame_s;
    logic                   drain_last_s;

    scan_counter #(
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .FRAME_WIDTH  (FRAME_WIDTH)
    ) u_scan_counter (
        .clock     (clock),
        .n_rst     (n_rst),
        .clear     (clear_s),
        .adv       (run_adv_s),
        .vcnt      (vcnt_s),
        .hcnt      (hcnt_s),
        .frame_end (frame_end_s)
    );

    assign active_s     = (vcnt_s < VW'(IMAGE_HEIGHT)) && (hcnt_s < HW'(IMAGE_WIDTH));
    assign clear_s      = (state_r == ST_IDLE) && start;
    assign src_ready    = (state_r == ST_RUN) && active_s && !dst_stall;
    // Blanking advances freely; an active position waits for the source.
    assign run_adv_s    = (state_r == ST_RUN) && !dst_stall && (!active_s || src_valid);
    // Compared one bit wider so the largest frame count cannot wrap.
    assign last_frame_s = (FW'(frame_cnt_r) + FW'(1)) == FW'(nf_r);
    assign drain_last_s = (drain_cnt_r == DW'(DRAIN_CYCLES - 1));

    // Next-state and advance decode.
    always_comb begin
        state_next_s = state_r;
        adv_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                adv_s = run_adv_s;
                if (frame_end_s && last_frame_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                adv_s = !dst_stall;
                if (adv_s && drain_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, frame count and drain count.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            nf_r        <= '0;
            frame_cnt_r <= '0;
            drain_cnt_r <= '0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nf_r        <= (num_frames == '0) ? FRAMES_BITW'(1) : num_frames;
                        frame_cnt_r <= '0;
                        drain_cnt_r <= '0;
                    end
                end
                ST_RUN: begin
                    if (frame_end_s) begin
                        frame_cnt_r <= frame_cnt_r + FRAMES_BITW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (adv_s) begin
                        drain_cnt_r <= drain_cnt_r + DW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered pipeline outputs and status.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            out_enable <= 1'b0;
            out_pixel  <= '0;
            out_vcnt   <= '0;
            out_hcnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            out_enable <= adv_s;
            busy       <= (state_next_s != ST_IDLE);
            done       <= (state_next_s == ST_DONE);
            if (adv_s) begin
                if (state_r == ST_DRAIN) begin
                    out_pixel <= '0;
                    out_vcnt  <= VW'(FRAME_HEIGHT - 1);
                    out_hcnt  <= HW'(FRAME_WIDTH - 1);
                end else begin
                    out_pixel <= active_s ? src_pixel : '0;
                    out_vcnt  <= vcnt_s;
                    out_hcnt  <= hcnt_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_scan_ctrl.sv
// Scoreboard bench for stream_scan_ctrl on a 4x3 image inside a 6x4 frame.
module tb_stream_scan_ctrl;
    import stream_pkg::*;

    localparam int BW = 8;
    localparam int IH = 3;
    localparam int IW = 4;
    localparam int FH = 4;
    localparam int FWD = 6;
    localparam int DR = 10;
    localparam int NB = 16;

    logic          clock;
    logic          n_rst;
    logic          start;
    logic [NB-1:0] num_frames;
    logic          busy;
    logic          done;
    logic          src_valid;
    logic [BW-1:0] src_pixel;
    logic          src_ready;
    logic          dst_stall;
    logic          out_enable;
    logic [BW-1:0] out_pixel;
    logic [1:0]    out_vcnt;
    logic [2:0]    out_hcnt;

    stream_scan_ctrl #(
        .BIT_WIDTH(BW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
        .FRAME_HEIGHT(FH), .FRAME_WIDTH(FWD), .DRAIN_CYCLES(DR), .FRAMES_BITW(NB)
    ) dut (
        .clock(clock), .n_rst(n_rst), .start(start), .num_frames(num_frames),
        .busy(busy), .done(done), .src_valid(src_valid), .src_pixel(src_pixel),
        .src_ready(src_ready), .dst_stall(dst_stall), .out_enable(out_enable),
        .out_pixel(out_pixel), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
    );

    typedef struct {
        int v;
        int h;
        int p;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pix_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   done_cyc = 0;
    bit   done_seen = 1'b0;
    bit   prev_done = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe pops the next expected raster entry.
    always @(negedge clock) begin
        if (n_rst) begin
            if (out_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_vcnt", int'(out_vcnt), mon_e.v);
                    check("out_hcnt", int'(out_hcnt), mon_e.h);
                    check("out_pixel", int'(out_pixel), mon_e.p);
                end
            end
            if (src_valid && src_ready) hs_cnt++;
            if (dst_stall) check("src_ready_under_stall", int'(src_ready), 0);
            if (done) begin
                check("done_single_cycle", int'(prev_done), 0);
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            prev_done = done;
        end
    end

    // Reference model: the k-th active raster position carries the k-th source pixel.
    task automatic build_expect(input int nfe);
        int k;
        k = 0;
        for (int f = 0; f < nfe; f++)
            for (int v = 0; v < FH; v++)
                for (int h = 0; h < FWD; h++) begin
                    if (v < IH && h < IW) begin
                        exp_q.push_back('{v, h, pix_q[k]});
                        k++;
                    end else begin
                        exp_q.push_back('{v, h, 0});
                    end
                end
        for (int d = 0; d < DR; d++) exp_q.push_back('{FH - 1, FWD - 1, 0});
    endtask

    task automatic begin_run(input int nf, input bit seq, output int t0);
        int nfe;
        nfe = (nf == 0) ? 1 : nf;
        pix_q.delete();
        exp_q.delete();
        hs_cnt    = 0;
        done_seen = 1'b0;
        for (int i = 0; i < nfe * IH * IW; i++)
            pix_q.push_back(seq ? ((i + 1) & 255) : int'($urandom_range(0, 255)));
        build_expect(nfe);
        @(posedge clock); #1;
        start      = 1'b1;
        num_frames = NB'(nf);
        src_valid  = 1'b0;
        dst_stall  = 1'b0;
        @(posedge clock); #1;
        t0         = cyc;
        start      = 1'b0;
        num_frames = NB'($urandom_range(0, 65535));
    endtask

    task automatic drive(input int mode, input int c);
        src_pixel = (hs_cnt < pix_q.size()) ? BW'(pix_q[hs_cnt]) : BW'($urandom_range(0, 255));
        start     = (c == 5);
        case (mode)
            1: begin src_valid = !(c >= 8 && c <= 10); dst_stall = 1'b0; end
            2: begin src_valid = 1'b1; dst_stall = (c >= 4 && c <= 8) || c == 31 || c == 32; end
            3: begin src_valid = ($urandom_range(0, 3) != 0); dst_stall = ($urandom_range(0, 4) == 0); end
            default: begin src_valid = 1'b1; dst_stall = 1'b0; end
        endcase
    endtask

    // mode: 0 clean, 1 starve at (1,2), 2 back-pressure, 3 random; exp_lat<0 skips latency.
    task automatic run(input int nf, input int mode, input int exp_lat);
        int t0;
        int c;
        int nfe;
        nfe = (nf == 0) ? 1 : nf;
        begin_run(nf, mode != 3, t0);
        c = 0;
        while (!done_seen && c < nfe * FH * FWD * 8 + 200) begin
            drive(mode, c);
            @(posedge clock); #1;
            c++;
            if (c == 2) check("busy_running", int'(busy), 1);
        end
        start     = 1'b0;
        src_valid = 1'b0;
        dst_stall = 1'b0;
        check("done_seen", int'(done_seen), 1);
        if (exp_lat >= 0) check("done_latency", done_cyc - t0, exp_lat);
        check("strobes_left", exp_q.size(), 0);
        check("handshakes", hs_cnt, nfe * IH * IW);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_out_enable"}, int'(out_enable), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_out_pixel"}, int'(out_pixel), 0);
        check({tag, "_out_vcnt"}, int'(out_vcnt), 0);
        check({tag, "_out_hcnt"}, int'(out_hcnt), 0);
        check({tag, "_src_ready"}, int'(src_ready), 0);
    endtask

    task automatic reset_midframe();
        int t0;
        begin_run(1, 1'b1, t0);
        for (int c = 0; c < 13; c++) begin
            drive(0, c);
            @(posedge clock); #1;
        end
        n_rst = 1'b0;
        @(posedge clock); #1;
        check_quiet("midreset");
        n_rst     = 1'b1;
        src_valid = 1'b0;
        exp_q.delete();
        done_seen = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("no_done_after_reset", int'(done_seen), 0);
        check("idle_after_reset", int'(busy), 0);
    endtask

    initial begin
        n_rst      = 1'b0;
        start      = 1'b0;
        num_frames = '0;
        src_valid  = 1'b0;
        src_pixel  = '0;
        dst_stall  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset");
        n_rst = 1'b1;

        run(1, 0, FH * FWD + DR);
        run(1, 1, FH * FWD + DR + 3);
        run(1, 2, FH * FWD + DR + 7);
        run(3, 0, 3 * FH * FWD + DR);
        run(0, 0, FH * FWD + DR);
        reset_midframe();
        run(1, 0, FH * FWD + DR);
        run(2, 3, -1);
        run(0, 3, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
